// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory model: independent single-outstanding write (AW/W/B) and
// read (AR/R) paths over a word-addressed RAM. All outputs are registered.
module axi_slave_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic       {R_IDLE, R_DATA}         rst_t;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wst_t                  wst_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [7:0]            wlen_q, wbeat_q;
  logic [IW-1:0]         widx_q;

  rst_t                  rst_q;
  logic                  arready_q, rvalid_q, rlast_q, rerr_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            rlen_q, rbeat_q;
  logic [IW-1:0]         ridx_q;

  logic          w_hs, werr_d, wr_en, ar_bad;
  logic [IW-1:0] aw_idx, ar_idx;

  // Upper (aliased) and byte-offset address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:IW+OFF], awaddr[OFF-1:0],
                              araddr[ADDR_WIDTH-1:IW+OFF], araddr[OFF-1:0]};

  assign aw_idx = awaddr[IW+OFF-1:OFF];
  assign ar_idx = araddr[IW+OFF-1:OFF];
  assign ar_bad = (arburst != 2'b01);
  assign w_hs   = wvalid & wready_q;
  // Error is sticky; a beat flags it when wlast disagrees with beat == awlen.
  assign werr_d = werr_q | (wlast != (wbeat_q == wlen_q));
  // A beat writes only if the burst was clean before it; reset aborts it.
  assign wr_en  = w_hs & ~werr_q & reset;

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem_q[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  // Write FSM: accept AW, absorb W beats until wlast, then hold B until bready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      widx_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wst_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= awid;
            wlen_q    <= awlen;
            wbeat_q   <= '0;
            widx_q    <= aw_idx;
            werr_q    <= (awburst != 2'b01);
            wst_q     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx_q  <= widx_q + 1'b1;
            wbeat_q <= wbeat_q + 8'd1;
            werr_q  <= werr_d;
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= werr_d ? 2'b10 : 2'b00;
              wst_q    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            wst_q     <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: beat 0 loads on the AR handshake edge, each R handshake loads
  // the next beat on the same edge. RAM is read before any same-edge write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      ridx_q    <= '0;
    end else begin
      case (rst_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= arid;
            rlen_q    <= arlen;
            rbeat_q   <= '0;
            rerr_q    <= ar_bad;
            rresp_q   <= ar_bad ? 2'b10 : 2'b00;
            rdata_q   <= ar_bad ? '0 : mem_q[ar_idx];
            rlast_q   <= (arlen == 8'd0);
            ridx_q    <= ar_idx + 1'b1;
            rst_q     <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rdata_q   <= '0;
              rresp_q   <= 2'b00;
              arready_q <= 1'b1;
              rst_q     <= R_IDLE;
            end else begin
              rdata_q <= rerr_q ? '0 : mem_q[ridx_q];
              ridx_q  <= ridx_q + 1'b1;
              rbeat_q <= rbeat_q + 8'd1;
              rlast_q <= (rbeat_q + 8'd1 == rlen_q);
            end
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
endmodule
